// File: rtl/x1_cegen.sv
// rtl/x1_cegen.sv - programmable multi-channel pe/ne clock-enable generator
module x1_cegen #(
  parameter int NCH    = 4,
  parameter int DW     = 8,
  parameter int SELW   = 2,
  parameter int REF_CH = 3,
  parameter logic [NCH*DW-1:0] DIV_INIT = {8'd15, 8'd7, 8'd3, 8'd1}
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic [NCH-1:0]   ch_en,
  input  logic [NCH-1:0]   hold,
  input  logic [NCH-1:0]   lock,
  input  logic             div_we,
  input  logic [SELW-1:0]  div_sel,
  input  logic [DW-1:0]    div_wdata,
  output logic [NCH-1:0]   pend,
  output logic [NCH-1:0]   pe,
  output logic [NCH-1:0]   ne
);

  logic [DW-1:0]  cnt    [NCH];
  logic [DW-1:0]  div_a  [NCH];
  logic [DW-1:0]  div_p  [NCH];
  logic [DW:0]    half   [NCH];
  logic [NCH-1:0] run;
  logic [NCH-1:0] hold_q;
  logic [NCH-1:0] adv;
  logic [NCH-1:0] wrap;
  logic [NCH-1:0] force0;
  logic [NCH-1:0] apply;
  logic [NCH-1:0] wr_hit;
  logic [DW-1:0]  wdata_eff;

  // A zero divisor would give a one-cycle period with pe and ne colliding; clamp to 1.
  assign wdata_eff = (div_wdata == '0) ? DW'(1) : div_wdata;

  // Per-channel advance/wrap/lock decode and the points where a pending divisor may land.
  always_comb begin
    adv    = '0;
    wrap   = '0;
    force0 = '0;
    apply  = '0;
    wr_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      adv[i]    = ch_en[i] & run[i] & ~hold_q[i];
      wrap[i]   = adv[i] & (cnt[i] == div_a[i]);
      wr_hit[i] = div_we & (div_sel == SELW'(i));
    end
    for (int i = 0; i < NCH; i++) begin
      // wrap[REF_CH] already implies the reference is running and not held
      force0[i] = (i != REF_CH) & lock[i] & run[i] & wrap[REF_CH];
      apply[i]  = ~run[i] | ~ch_en[i] | wrap[i] | force0[i];
    end
  end

  // Counters, run/hold sampling and the active/pending divisor handshake.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      run    <= '0;
      hold_q <= '0;
      pend   <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i]   <= '0;
        div_a[i] <= DIV_INIT[i*DW +: DW];
        div_p[i] <= '0;
      end
    end else begin
      run    <= ch_en;
      // hold is sampled like ch_en so the strobes depend on registers only
      hold_q <= hold;
      for (int i = 0; i < NCH; i++) begin
        if (!ch_en[i] || force0[i] || wrap[i]) begin
          cnt[i] <= '0;
        end else if (adv[i]) begin
          cnt[i] <= cnt[i] + DW'(1);
        end
        if (apply[i] && pend[i]) begin
          div_a[i] <= div_p[i];
        end
        // a write landing on an apply edge stays pending for the next one
        if (wr_hit[i]) begin
          div_p[i] <= wdata_eff;
          pend[i]  <= 1'b1;
        end else if (apply[i]) begin
          pend[i]  <= 1'b0;
        end
      end
    end
  end

  // Strobe decode from registered state; ne sits at floor(period/2).
  always_comb begin
    pe = '0;
    ne = '0;
    for (int i = 0; i < NCH; i++) begin
      half[i] = ({1'b0, div_a[i]} + {{DW{1'b0}}, 1'b1}) >> 1;
      pe[i]   = run[i] & ~hold_q[i] & (cnt[i] == '0);
      ne[i]   = run[i] & ~hold_q[i] & ({1'b0, cnt[i]} == half[i]);
    end
  end

endmodule

// File: tb/tb_x1_cegen.sv
// tb/tb_x1_cegen.sv - directed self-checking bench for x1_cegen
module tb_x1_cegen;

  logic       clk_sys;
  logic       reset_n;
  logic [3:0] ch_en;
  logic [3:0] hold;
  logic [3:0] lock;
  logic       div_we;
  logic [2:0] div_sel;
  logic [7:0] div_wdata;
  logic [3:0] pend;
  logic [3:0] pe;
  logic [3:0] ne;

  int n_cmp;
  int n_bad;

  x1_cegen #(
    .NCH(4), .DW(8), .SELW(3), .REF_CH(3), .DIV_INIT(32'h0F070301)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ch_en(ch_en), .hold(hold), .lock(lock),
    .div_we(div_we), .div_sel(div_sel), .div_wdata(div_wdata),
    .pend(pend), .pe(pe), .ne(ne)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic do_reset;
    reset_n = 1'b0; ch_en = '0; hold = '0; lock = '0;
    div_we = 1'b0; div_sel = '0; div_wdata = '0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; ch_en = '0; hold = '0; lock = '0;
    div_we = 1'b0; div_sel = '0; div_wdata = '0;
    #3;
    n_cmp++; if (pe !== 4'h0) begin n_bad++; $display("FAIL reset_pe got=%h exp=0", pe); end
    n_cmp++; if (ne !== 4'h0) begin n_bad++; $display("FAIL reset_ne got=%h exp=0", ne); end
    n_cmp++; if (pend !== 4'h0) begin n_bad++; $display("FAIL reset_pend got=%h exp=0", pend); end
  endtask

  task automatic test_free_run;
    logic [3:0] ep, en;
    do_reset();
    ch_en = 4'hF;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk_sys);
      for (int i = 0; i < 4; i++) begin
        ep[i] = ((k % (2 << i)) == 0);
        en[i] = ((k % (2 << i)) == (1 << i));
      end
      n_cmp++; if (pe !== ep) begin n_bad++; $display("FAIL free_pe k=%0d got=%h exp=%h", k, pe, ep); end
      n_cmp++; if (ne !== en) begin n_bad++; $display("FAIL free_ne k=%0d got=%h exp=%h", k, ne, en); end
    end
  endtask

  task automatic test_div_write;
    int c, hh;
    logic [3:0] ep, en, epd;
    do_reset();
    ch_en = 4'b0100;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk_sys);
      c   = (k < 8) ? k : (k < 24) ? ((k - 8) % 4) : ((k - 24) % 8);
      hh  = (k >= 8 && k < 24) ? 2 : 4;
      ep  = {1'b0, c == 0, 2'b00};
      en  = {1'b0, c == hh, 2'b00};
      epd = ((k >= 3 && k < 8) || (k >= 20 && k < 24)) ? 4'b0100 : 4'b0000;
      n_cmp++; if (pe !== ep) begin n_bad++; $display("FAIL wr_pe k=%0d got=%h exp=%h", k, pe, ep); end
      n_cmp++; if (ne !== en) begin n_bad++; $display("FAIL wr_ne k=%0d got=%h exp=%h", k, ne, en); end
      n_cmp++; if (pend !== epd) begin n_bad++; $display("FAIL wr_pend k=%0d got=%h exp=%h", k, pend, epd); end
      if (k == 2 || k == 19) begin
        div_we = 1'b1; div_sel = 3'd2; div_wdata = (k == 2) ? 8'd3 : 8'd7;
      end else begin
        div_we = 1'b0;
      end
    end
  endtask

  task automatic test_div_zero_badsel;
    int c, hh;
    logic [3:0] ep, en, epd;
    do_reset();
    ch_en = 4'b0010;
    for (int k = 0; k <= 24; k++) begin
      @(negedge clk_sys);
      c   = (k < 4) ? k : (k % 2);
      hh  = (k < 4) ? 2 : 1;
      ep  = {2'b00, c == 0, 1'b0};
      en  = {2'b00, c == hh, 1'b0};
      epd = (k >= 1 && k < 4) ? 4'b0010 : 4'b0000;
      n_cmp++; if (pe !== ep) begin n_bad++; $display("FAIL zero_pe k=%0d got=%h exp=%h", k, pe, ep); end
      n_cmp++; if (ne !== en) begin n_bad++; $display("FAIL zero_ne k=%0d got=%h exp=%h", k, ne, en); end
      n_cmp++; if (pend !== epd) begin n_bad++; $display("FAIL zero_pend k=%0d got=%h exp=%h", k, pend, epd); end
      div_we = 1'b0;
      if (k == 0)  begin div_we = 1'b1; div_sel = 3'd1; div_wdata = 8'd0; end
      if (k == 10) begin div_we = 1'b1; div_sel = 3'd5; div_wdata = 8'd9; end
      if (k == 14) begin div_we = 1'b1; div_sel = 3'd4; div_wdata = 8'd0; end
    end
  endtask

  task automatic test_hold;
    logic [3:0] ep, en;
    do_reset();
    ch_en = 4'b0100;
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk_sys);
      ep = {1'b0, (k == 0 || k == 13 || k == 22 || k == 30), 2'b00};
      en = {1'b0, (k == 9 || k == 17 || k == 26 || k == 34), 2'b00};
      n_cmp++; if (pe !== ep) begin n_bad++; $display("FAIL hold_pe k=%0d got=%h exp=%h", k, pe, ep); end
      n_cmp++; if (ne !== en) begin n_bad++; $display("FAIL hold_ne k=%0d got=%h exp=%h", k, ne, en); end
      if (k == 3)  hold = 4'b0100;
      if (k == 8)  hold = 4'b0000;
      if (k == 18) hold = 4'b0100;
      if (k == 19) ch_en = 4'b0000;
      if (k == 21) begin hold = 4'b0000; ch_en = 4'b0100; end
    end
  endtask

  task automatic test_lock;
    int c1;
    logic [3:0] ep, en;
    do_reset();
    div_we = 1'b1; div_sel = 3'd1; div_wdata = 8'd2;
    @(negedge clk_sys);
    div_we = 1'b0;
    n_cmp++; if (pend !== 4'b0010) begin n_bad++; $display("FAIL lock_pend_set got=%h exp=2", pend); end
    @(negedge clk_sys);
    n_cmp++; if (pend !== 4'b0000) begin n_bad++; $display("FAIL lock_pend_stopped got=%h exp=0", pend); end
    ch_en = 4'b1010; lock = 4'b0010;
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk_sys);
      c1 = (k < 48) ? ((k % 16) % 3) : ((k - 32) % 3);
      ep = {(k % 16) == 0, 1'b0, c1 == 0, 1'b0};
      en = {(k % 16) == 8, 1'b0, c1 == 1, 1'b0};
      n_cmp++; if (pe !== ep) begin n_bad++; $display("FAIL lock_pe k=%0d got=%h exp=%h", k, pe, ep); end
      n_cmp++; if (ne !== en) begin n_bad++; $display("FAIL lock_ne k=%0d got=%h exp=%h", k, ne, en); end
      if (k == 40) lock = 4'b0000;
    end
  endtask

  task automatic test_async_reset;
    logic [3:0] ep;
    do_reset();
    ch_en = 4'b0100;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk_sys);
      div_we = (k == 2);
      div_sel = 3'd2; div_wdata = 8'd3;
    end
    n_cmp++; if (ne !== 4'b0100) begin n_bad++; $display("FAIL areset_pre_ne got=%h exp=4", ne); end
    n_cmp++; if (pend !== 4'b0100) begin n_bad++; $display("FAIL areset_pre_pend got=%h exp=4", pend); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (pe !== 4'h0) begin n_bad++; $display("FAIL areset_pe got=%h exp=0", pe); end
    n_cmp++; if (ne !== 4'h0) begin n_bad++; $display("FAIL areset_ne got=%h exp=0", ne); end
    n_cmp++; if (pend !== 4'h0) begin n_bad++; $display("FAIL areset_pend got=%h exp=0", pend); end
    ch_en = '0;
    @(negedge clk_sys);
    reset_n = 1'b1;
    ch_en = 4'hF;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk_sys);
      for (int i = 0; i < 4; i++) ep[i] = ((k % (2 << i)) == 0);
      n_cmp++; if (pe !== ep) begin n_bad++; $display("FAIL areset_init_pe k=%0d got=%h exp=%h", k, pe, ep); end
      n_cmp++; if (pend !== 4'h0) begin n_bad++; $display("FAIL areset_init_pend k=%0d got=%h exp=0", k, pend); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_free_run();
    test_div_write();
    test_div_zero_badsel();
    test_hold();
    test_lock();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
